// File: rtl/saida_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : saida_led_sequencer
//  Purpose  : Turns the static 4-bit PIO command into an animated LED pattern
//             (OFF / ON / CHASE / BOUNCE) with a programmable step period.
//             Optional macro SAIDA_SEQ_CMD_FILTER_EN adds a two-sample
//             command filter that rejects single-cycle glitches on cmd.
//  Revision : 1.0  initial release
// ============================================================================
module saida_led_sequencer #(
   parameter int LED_W   = 8,
   parameter int CLK_DIV = 12500000,
   parameter int CNT_W   = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       cmd,
   output logic [LED_W-1:0] leds,
   output logic             step,
   output logic             active
);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_ON       = 3'd1,
      ST_CHASE    = 3'd2,
      ST_BOUNCE_L = 3'd3,
      ST_BOUNCE_R = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] c_div = CNT_W'(CLK_DIV);

   state_t             r_state;
   logic [LED_W-1:0]   r_leds;
   logic               r_step;
   logic               r_active;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_cmd_q;

   state_t             w_state_nx;
   logic [LED_W-1:0]   w_leds_nx;
   logic               w_step_nx;
   logic               w_active_nx;
   logic [CNT_W-1:0]   w_cnt_nx;
   logic [3:0]         w_cmd_nx;
   logic               w_accept;
   logic [CNT_W-1:0]   w_last;
   logic               w_animated;

`ifdef SAIDA_SEQ_CMD_FILTER_EN
   logic [3:0] r_cand;

   // Candidate register: remembers last sampled cmd so a value must persist two edges
   always_ff @(posedge clk) begin
      if (reset) r_cand <= 4'd0;
      else       r_cand <= cmd;
   end

   assign w_accept = (cmd == r_cand) && (cmd != r_cmd_q);
`else
   assign w_accept = (cmd != r_cmd_q);
`endif

   // Terminal prescaler count for the accepted speed: (CLK_DIV << s) - 1
   assign w_last     = (c_div << r_cmd_q[3:2]) - CNT_W'(1);
   assign w_animated = (r_state == ST_CHASE) || (r_state == ST_BOUNCE_L) ||
                       (r_state == ST_BOUNCE_R);

   // Register stage: state, pattern, prescaler and accepted command
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_OFF;
         r_leds   <= '0;
         r_step   <= 1'b0;
         r_active <= 1'b0;
         r_cnt    <= '0;
         r_cmd_q  <= 4'd0;
      end else begin
         r_state  <= w_state_nx;
         r_leds   <= w_leds_nx;
         r_step   <= w_step_nx;
         r_active <= w_active_nx;
         r_cnt    <= w_cnt_nx;
         r_cmd_q  <= w_cmd_nx;
      end
   end

   // Next-state logic: command acceptance has priority over a pattern step
   always_comb begin
      w_state_nx = r_state;
      w_leds_nx  = r_leds;
      w_step_nx  = 1'b0;
      w_cnt_nx   = r_cnt;
      w_cmd_nx   = r_cmd_q;

      if (w_accept) begin
         w_cmd_nx = cmd;
         w_cnt_nx = '0;
         // A speed-only change keeps the current pattern position
         if (cmd[1:0] != r_cmd_q[1:0]) begin
            case (cmd[1:0])
               2'd0: begin
                  w_state_nx = ST_OFF;
                  w_leds_nx  = '0;
               end
               2'd1: begin
                  w_state_nx = ST_ON;
                  w_leds_nx  = '1;
               end
               2'd2: begin
                  w_state_nx = ST_CHASE;
                  w_leds_nx  = LED_W'(1);
               end
               default: begin
                  w_state_nx = ST_BOUNCE_L;
                  w_leds_nx  = LED_W'(1);
               end
            endcase
         end
      end else if (w_animated) begin
         if (r_cnt == w_last) begin
            w_cnt_nx  = '0;
            w_step_nx = 1'b1;
            case (r_state)
               ST_CHASE: begin
                  w_leds_nx = {r_leds[LED_W-2:0], r_leds[LED_W-1]};
               end
               ST_BOUNCE_L: begin
                  w_leds_nx = {r_leds[LED_W-2:0], 1'b0};
                  // Turn around on the very step that lands on the MSB
                  if (r_leds[LED_W-2]) w_state_nx = ST_BOUNCE_R;
               end
               default: begin
                  w_leds_nx = {1'b0, r_leds[LED_W-1:1]};
                  if (r_leds[1]) w_state_nx = ST_BOUNCE_L;
               end
            endcase
         end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
         end
      end else begin
         w_cnt_nx = '0;
      end

      w_active_nx = (w_state_nx == ST_CHASE) || (w_state_nx == ST_BOUNCE_L) ||
                    (w_state_nx == ST_BOUNCE_R);
   end

   assign leds   = r_leds;
   assign step   = r_step;
   assign active = r_active;

endmodule
`default_nettype wire
